// File: rtl/pico_io_stream_if.sv
// AXI4-Stream byte channel carrying the kcpsm6 output FIFO to the fabric.
interface pico_io_stream_if;
  logic [7:0] m_tdata;
  logic       m_tvalid;
  logic       m_tlast;
  logic       m_tready;

  modport master (
    output m_tdata,
    output m_tvalid,
    output m_tlast,
    input  m_tready
  );

  modport slave (
    input  m_tdata,
    input  m_tvalid,
    input  m_tlast,
    output m_tready
  );
endinterface

// File: rtl/pico_io_stream.sv
// kcpsm6 I/O port decoder with registered in/out ports, a status port and a
// first-word-fall-through FIFO feeding an AXI4-Stream master.
module pico_io_stream #(
  parameter int unsigned N_IN       = 8,
  parameter int unsigned N_OUT      = 8,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [7:0]           port_id,
  input  logic                 write_strobe,
  input  logic                 read_strobe,
  input  logic [7:0]           out_port,
  output logic [7:0]           in_port,
  input  logic [8*N_IN-1:0]    in_bus,
  output logic [N_IN-1:0]      in_ack,
  output logic [8*N_OUT-1:0]   out_bus,
  output logic [N_OUT-1:0]     out_stb,
  pico_io_stream_if.master     m_axis
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  localparam logic [7:0] ADDR_STATUS    = 8'hFD;
  localparam logic [7:0] ADDR_PUSH      = 8'hFE;
  localparam logic [7:0] ADDR_PUSH_LAST = 8'hFF;

  logic [7:0]         in_port_q, in_port_d;
  logic [N_IN-1:0]    in_ack_q,  in_ack_d;
  logic [8*N_OUT-1:0] out_bus_q, out_bus_d;
  logic [N_OUT-1:0]   out_stb_q, out_stb_d;

  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q,  count_d;
  logic               ovf_q,    ovf_d;
  logic [8:0]         mem_q [FIFO_DEPTH];

  logic               full;
  logic               empty;
  logic [7:0]         status;
  logic               push_req;
  logic               push_acc;
  logic               pop;
  logic [8:0]         push_word;
  logic [8:0]         head_word;

  // FIFO bookkeeping; the full test uses the pre-edge count, so a push into a
  // full FIFO is dropped even when a pop happens on the same edge.
  always_comb begin
    full      = (count_q == CW'(FIFO_DEPTH));
    empty     = (count_q == '0);
    status    = {full, empty, ovf_q, 5'(count_q)};
    push_req  = write_strobe && ((port_id == ADDR_PUSH) || (port_id == ADDR_PUSH_LAST));
    push_acc  = push_req && !full;
    pop       = !empty && m_axis.m_tready;
    push_word = {(port_id == ADDR_PUSH_LAST), out_port};
    head_word = mem_q[rd_ptr_q];

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_acc) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)      rd_ptr_d = rd_ptr_q + AW'(1);
    if (push_acc && !pop)      count_d = count_q + CW'(1);
    else if (!push_acc && pop) count_d = count_q - CW'(1);

    // Set takes priority over a same-edge clear.
    ovf_d = ovf_q;
    if (write_strobe && (port_id == ADDR_STATUS)) ovf_d = 1'b0;
    if (push_req && full)                         ovf_d = 1'b1;
  end

  // Port decode over the full 8-bit address space.
  always_comb begin
    in_port_d = '0;
    in_ack_d  = '0;
    out_bus_d = out_bus_q;
    out_stb_d = '0;

    if (port_id == ADDR_STATUS) in_port_d = status;

    for (int unsigned p = 0; p < N_IN; p++) begin
      if (32'(port_id) == p) begin
        in_port_d   = in_bus[8*p +: 8];
        in_ack_d[p] = read_strobe;
      end
    end

    for (int unsigned p = 0; p < N_OUT; p++) begin
      if (write_strobe && (32'(port_id) == p)) begin
        out_bus_d[8*p +: 8] = out_port;
        out_stb_d[p]        = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_port_q <= '0;
      in_ack_q  <= '0;
      out_bus_q <= '0;
      out_stb_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
    end else begin
      in_port_q <= in_port_d;
      in_ack_q  <= in_ack_d;
      out_bus_q <= out_bus_d;
      out_stb_q <= out_stb_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
    end
  end

  // Storage needs no reset: reads are masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push_acc) mem_q[wr_ptr_q] <= push_word;
  end

  assign in_port  = in_port_q;
  assign in_ack   = in_ack_q;
  assign out_bus  = out_bus_q;
  assign out_stb  = out_stb_q;

  assign m_axis.m_tvalid = !empty;
  assign m_axis.m_tdata  = empty ? '0   : head_word[7:0];
  assign m_axis.m_tlast  = empty ? 1'b0 : head_word[8];

endmodule
